quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 143 ++++++++++++++
 tb/tb_quad_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop synchronisers, per-channel glitch filters, step classifier
// producing up/down/err pulses, last direction and a saturating error count.
module quad_decoder #(
   parameter int unsigned FILTER_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       qa,
   input  logic       qb,
   input  logic       err_clr,
   output logic       up,
   output logic       down,
   output logic       err,
   output logic       dir,
   output logic [3:0] err_count
);

   typedef enum logic {StInit, StRun} state_t;

   localparam logic [3:0] CntLast  = 4'(FILTER_CYCLES - 1);
   localparam logic [1:0] InitLast = 2'd2;
   localparam logic [3:0] ErrMax   = 4'd15;

   state_t     state;
   logic [1:0] init_cnt;
   // Bit 1 carries channel A, bit 0 channel B throughout.
   logic [1:0] s1;
   logic [1:0] s2;
   logic [1:0] f;
   logic [1:0] prev;
   logic [3:0] cnt_a;
   logic [3:0] cnt_b;

   logic [1:0] f_nxt;
   logic [3:0] cnt_a_nxt;
   logic [3:0] cnt_b_nxt;
   logic [1:0] fwd_next;
   logic [1:0] rev_next;
   logic       step_fwd;
   logic       step_rev;
   logic       step_bad;

   // Returns {new filtered bit, new counter}.
   function automatic logic [4:0] filt(input logic s, input logic fv, input logic [3:0] c);
      logic [4:0] r;
      if (s == fv) begin
         r = {fv, 4'd0};
      end else if (c == CntLast) begin
         r = {s, 4'd0};
      end else begin
         r = {fv, c + 4'd1};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 2'b00;
         s2 <= 2'b00;
      end else begin
         s1 <= {qa, qb};
         s2 <= s1;
      end
   end

   always_comb begin
      {f_nxt[1], cnt_a_nxt} = filt(s2[1], f[1], cnt_a);
      {f_nxt[0], cnt_b_nxt} = filt(s2[0], f[0], cnt_b);
   end

   // Successor of prev in each rotation of the Gray cycle 00-01-11-10.
   always_comb begin
      fwd_next = 2'b00;
      rev_next = 2'b00;
      case (prev)
         2'b00: begin fwd_next = 2'b01; rev_next = 2'b10; end
         2'b01: begin fwd_next = 2'b11; rev_next = 2'b00; end
         2'b11: begin fwd_next = 2'b10; rev_next = 2'b01; end
         2'b10: begin fwd_next = 2'b00; rev_next = 2'b11; end
         default: begin fwd_next = 2'b00; rev_next = 2'b00; end
      endcase
      step_fwd = (f == fwd_next);
      step_rev = (f == rev_next);
      step_bad = &(f ^ prev);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StInit;
         init_cnt  <= 2'd0;
         f         <= 2'b00;
         prev      <= 2'b00;
         cnt_a     <= 4'd0;
         cnt_b     <= 4'd0;
         up        <= 1'b0;
         down      <= 1'b0;
         err       <= 1'b0;
         dir       <= 1'b0;
         err_count <= 4'd0;
      end else begin
         // Clear takes priority over an error pulse counted in the same cycle.
         if (err_clr) begin
            err_count <= 4'd0;
         end else if (err && (err_count != ErrMax)) begin
            err_count <= err_count + 4'd1;
         end

         case (state)
            StInit: begin
               // Track the settled input level so leaving INIT sees no transition.
               up    <= 1'b0;
               down  <= 1'b0;
               err   <= 1'b0;
               f     <= s2;
               prev  <= s2;
               cnt_a <= 4'd0;
               cnt_b <= 4'd0;
               if (init_cnt == InitLast) begin
                  state <= StRun;
               end else begin
                  init_cnt <= init_cnt + 2'd1;
               end
            end
            StRun: begin
               up    <= step_fwd;
               down  <= step_rev;
               err   <= step_bad;
               if (step_fwd) begin
                  dir <= 1'b1;
               end else if (step_rev) begin
                  dir <= 1'b0;
               end
               prev  <= f;
               f     <= f_nxt;
               cnt_a <= cnt_a_nxt;
               cnt_b <= cnt_b_nxt;
            end
            default: state <= StInit;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios with literal expectations plus randomised
// quadrature stimulus checked every cycle against a Gray-position reference model.
module tb_quad_decoder;

   localparam int FC = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       qa = 1'b0;
   logic       qb = 1'b0;
   logic       err_clr = 1'b0;
   logic       up;
   logic       down;
   logic       err;
   logic       dir;
   logic [3:0] err_count;

   always #5 clk = ~clk;

   quad_decoder #(.FILTER_CYCLES(FC)) dut (
      .clk       (clk),
      .reset     (reset),
      .qa        (qa),
      .qb        (qb),
      .err_clr   (err_clr),
      .up        (up),
      .down      (down),
      .err       (err),
      .dir       (dir),
      .err_count (err_count)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         m_n = 0;
   logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_f = 2'b00, m_prev = 2'b00, m_nf;
   int         m_run_a = 0, m_run_b = 0, m_step, m_ec = 0;
   logic       m_up = 1'b0, m_down = 1'b0, m_err = 1'b0, m_dir = 1'b0;

   // Observed pulse statistics
   int         n_up = 0, n_down = 0, n_err = 0, n_up_hi = 0, n_down_hi = 0;
   logic [2:0] ctr3 = 3'd0;
   logic       up_q = 1'b0, down_q = 1'b0, err_q = 1'b0;
   int         b_up, b_down, b_err, b_up_hi, b_down_hi;
   logic [2:0] b_ctr;
   int         lat;
   int         seg_len;

   function automatic int pos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_n = 0; m_s1 = 2'b00; m_s2 = 2'b00; m_f = 2'b00; m_prev = 2'b00;
         m_run_a = 0; m_run_b = 0;
         m_up = 1'b0; m_down = 1'b0; m_err = 1'b0; m_dir = 1'b0; m_ec = 0;
      end else begin
         if (err_clr) m_ec = 0;
         else if (m_err && m_ec < 15) m_ec++;
         m_n++;
         if (m_n <= 3) begin
            m_up = 1'b0; m_down = 1'b0; m_err = 1'b0;
            m_f = m_s2; m_prev = m_s2; m_run_a = 0; m_run_b = 0;
         end else begin
            m_step = (pos(m_f) - pos(m_prev) + 4) % 4;
            m_up   = (m_step == 1);
            m_down = (m_step == 3);
            m_err  = (m_step == 2);
            if (m_up) m_dir = 1'b1;
            else if (m_down) m_dir = 1'b0;
            m_prev = m_f;
            m_nf = m_f;
            if (m_s2[1] == m_f[1]) m_run_a = 0;
            else if (m_run_a == FC - 1) begin m_nf[1] = m_s2[1]; m_run_a = 0; end
            else m_run_a++;
            if (m_s2[0] == m_f[0]) m_run_b = 0;
            else if (m_run_b == FC - 1) begin m_nf[0] = m_s2[0]; m_run_b = 0; end
            else m_run_b++;
            m_f = m_nf;
         end
         m_s2 = m_s1;
         m_s1 = {qa, qb};
      end
   endtask

   task automatic compare_and_count();
      logic [7:0] act, exp;
      act = {up, down, err, dir, err_count};
      exp = {m_up, m_down, m_err, m_dir, 4'(m_ec)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cycle_compare t=%0t: got up/down/err/dir/cnt=%b, expected %b",
                  $time, act, exp);
      end
      if (!reset) begin
         if (up && !up_q) n_up++;
         if (down && !down_q) n_down++;
         if (err && !err_q) n_err++;
         if (up) begin n_up_hi++; ctr3 = ctr3 + 3'd1; end
         if (down) begin n_down_hi++; ctr3 = ctr3 - 3'd1; end
      end
      up_q = up; down_q = down; err_q = err;
   endtask

   task automatic snap();
      b_up = n_up; b_down = n_down; b_err = n_err;
      b_up_hi = n_up_hi; b_down_hi = n_down_hi; b_ctr = ctr3;
   endtask

   task automatic hold(input logic [1:0] v, input int n);
      {qa, qb} = v;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic reset_to(input logic [1:0] v);
      {qa, qb} = v;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      fork
         forever begin @(posedge clk or posedge reset); model_update(); end
         forever begin @(negedge clk); compare_and_count(); end
      join_none

      // Steady 11 through reset and INIT: nothing may fire.
      {qa, qb} = 2'b11;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      snap();
      repeat (10) @(negedge clk);
      #1;
      chk("init11_up", n_up - b_up, 0);
      chk("init11_down", n_down - b_down, 0);
      chk("init11_err", n_err - b_err, 0);
      chk("init11_err_count", int'(err_count), 0);
      chk("init11_dir", int'(dir), 0);

      // Forward rotation with latency probe on the first step.
      reset_to(2'b00);
      snap();
      {qa, qb} = 2'b01;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (up) begin lat = i; break; end
      end
      chk("fwd_latency_edges", lat, 6);
      @(negedge clk);
      #1;
      hold(2'b01, 4);
      hold(2'b11, 8);
      hold(2'b10, 8);
      hold(2'b00, 8);
      chk("fwd_up_pulses", n_up - b_up, 4);
      chk("fwd_up_high_cycles", n_up_hi - b_up_hi, 4);
      chk("fwd_down", n_down - b_down, 0);
      chk("fwd_err", n_err - b_err, 0);
      chk("fwd_dir", int'(dir), 1);
      chk("fwd_counter", int'(3'(ctr3 - b_ctr)), 4);

      // Reverse rotation: 3-bit counter 0->7->6->5->4.
      snap();
      hold(2'b10, 8);
      hold(2'b11, 8);
      hold(2'b01, 8);
      hold(2'b00, 8);
      chk("rev_down_pulses", n_down - b_down, 4);
      chk("rev_down_high_cycles", n_down_hi - b_down_hi, 4);
      chk("rev_up", n_up - b_up, 0);
      chk("rev_dir", int'(dir), 0);
      chk("rev_counter", int'(3'(ctr3 - b_ctr)), 4);

      // Two-cycle glitch on A is filtered out.
      snap();
      hold(2'b10, 2);
      hold(2'b00, 12);
      chk("glitch_up", n_up - b_up, 0);
      chk("glitch_down", n_down - b_down, 0);
      chk("glitch_err", n_err - b_err, 0);

      // Illegal double transitions and error counter saturation.
      reset_to(2'b00);
      snap();
      for (int i = 0; i < 17; i++) begin
         hold((i % 2 == 0) ? 2'b11 : 2'b00, 8);
         if (i == 14) chk("err_count_at_15", int'(err_count), 15);
      end
      chk("err_pulses", n_err - b_err, 17);
      chk("err_no_steps", (n_up - b_up) + (n_down - b_down), 0);
      chk("err_count_saturated", int'(err_count), 15);
      {qa, qb} = 2'b00;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (err) begin lat = i; break; end
      end
      chk("err_probe_found", lat, 6);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      chk("err_clr_wins", int'(err_count), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("err_count_stays_clear", int'(err_count), 0);

      // Reset one cycle before an expected up pulse.
      reset_to(2'b00);
      {qa, qb} = 2'b01;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_outputs", int'({up, down, err, dir, err_count}), 0);
      snap();
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("rst_no_up", n_up - b_up, 0);
      chk("rst_no_down", n_down - b_down, 0);
      chk("rst_no_err", n_err - b_err, 0);

      // Random segments; the per-cycle compare does the checking.
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            #1 reset = 1'b0;
         end
         {qa, qb} = 2'($urandom_range(0, 3));
         seg_len = int'($urandom_range(1, 12));
         for (int c = 0; c < seg_len; c++) begin
            err_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            #1;
         end
         err_clr = 1'b0;
      end
      repeat (12) @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
